// File: rtl/dice_roller_array.sv
// Multi-die roller: mixed-radix odometer spin with per-die holds, then a
// sequential face total and all-equal flag published with a one-cycle done pulse.
module dice_roller_array #(
  parameter int NUM_DICE = 2,
  parameter int FACES    = 6,
  localparam int FACE_W  = $clog2(FACES + 1),
  localparam int SUM_W   = $clog2(NUM_DICE * FACES + 1),
  localparam int IDX_W   = $clog2(NUM_DICE + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_DICE-1:0]          hold,
  output logic [NUM_DICE*FACE_W-1:0]   faces,
  output logic [SUM_W-1:0]             sum,
  output logic                         all_equal,
  output logic                         busy,
  output logic                         done,
  output logic                         result_valid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPIN,
    ST_SUM
  } state_e;

  state_e                             state_q, state_d;
  logic [NUM_DICE-1:0][FACE_W-1:0]    face_q, face_d;
  logic [SUM_W-1:0]                   acc_q, acc_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic                               eq_q, eq_d;
  logic [SUM_W-1:0]                   sum_q, sum_d;
  logic                               all_equal_q, all_equal_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  logic                               result_valid_q, result_valid_d;
  logic                               carry;
  logic [FACE_W-1:0]                  cur_face;

  always_comb begin
    state_d        = state_q;
    face_d         = face_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    eq_d           = eq_q;
    sum_d          = sum_q;
    all_equal_d    = all_equal_q;
    done_d         = 1'b0;
    result_valid_d = result_valid_q;
    carry          = 1'b1;
    cur_face       = face_q[0];

    for (int unsigned i = 0; i < NUM_DICE; i++) begin
      if (idx_q == IDX_W'(i)) cur_face = face_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d        = ST_SPIN;
          result_valid_d = 1'b0;
        end
      end
      ST_SPIN: begin
        if (enable) begin
          // Held dice are skipped entirely, so the carry passes straight through them.
          for (int unsigned i = 0; i < NUM_DICE; i++) begin
            if (!hold[i]) begin
              if (carry) begin
                face_d[i] = (face_q[i] == FACE_W'(FACES)) ? FACE_W'(1)
                                                          : face_q[i] + FACE_W'(1);
              end
              carry = carry & (face_q[i] == FACE_W'(FACES));
            end
          end
        end else begin
          state_d = ST_SUM;
          acc_d   = '0;
          idx_d   = '0;
          eq_d    = 1'b1;
        end
      end
      ST_SUM: begin
        acc_d = acc_q + SUM_W'(cur_face);
        idx_d = idx_q + IDX_W'(1);
        eq_d  = eq_q & (cur_face == face_q[0]);
        if (idx_q == IDX_W'(NUM_DICE - 1)) begin
          sum_d          = acc_d;
          all_equal_d    = eq_d;
          done_d         = 1'b1;
          result_valid_d = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      for (int unsigned i = 0; i < NUM_DICE; i++) face_q[i] <= FACE_W'(1);
      acc_q          <= '0;
      idx_q          <= '0;
      eq_q           <= 1'b1;
      sum_q          <= SUM_W'(NUM_DICE);
      all_equal_q    <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      face_q         <= face_d;
      acc_q          <= acc_d;
      idx_q          <= idx_d;
      eq_q           <= eq_d;
      sum_q          <= sum_d;
      all_equal_q    <= all_equal_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign faces        = face_q;
  assign sum          = sum_q;
  assign all_equal    = all_equal_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_dice_roller_array.sv
// Bench for dice_roller_array: two instances (2x d6, 3x d4) checked every cycle
// against an arithmetic odometer/roll model, plus directed literal expectations.
module tb_dice_roller_array;

  logic       clk;
  logic       rst_a, rst_b;
  logic       en_a, en_b;
  logic [1:0] hold_a;
  logic [2:0] hold_b;
  logic [5:0] faces_a;
  logic [8:0] faces_b;
  logic [3:0] sum_a, sum_b;
  logic       eq_a, eq_b, busy_a, busy_b, done_a, done_b, rv_a, rv_b;

  int n_cmp = 0;
  int n_err = 0;

  dice_roller_array #(.NUM_DICE(2), .FACES(6)) u_a (
    .clock(clk), .reset(rst_a), .enable(en_a), .hold(hold_a),
    .faces(faces_a), .sum(sum_a), .all_equal(eq_a), .busy(busy_a),
    .done(done_a), .result_valid(rv_a)
  );

  dice_roller_array #(.NUM_DICE(3), .FACES(4)) u_b (
    .clock(clk), .reset(rst_b), .enable(en_b), .hold(hold_b),
    .faces(faces_b), .sum(sum_b), .all_equal(eq_b), .busy(busy_b),
    .done(done_b), .result_valid(rv_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle, 1=spin, 2=summing (cnt edges remaining)
  int m_face[2][3];
  int m_mode[2], m_cnt[2], m_psum[2], m_peq[2];
  int m_sum[2], m_eq[2], m_done[2], m_rv[2];

  task automatic model_reset(input int k, input int n);
    for (int i = 0; i < 3; i++) m_face[k][i] = 1;
    m_mode[k] = 0; m_cnt[k] = 0; m_psum[k] = 0; m_peq[k] = 1;
    m_sum[k] = n; m_eq[k] = 1; m_done[k] = 0; m_rv[k] = 0;
  endtask

  // Spin = add one to the mixed-radix number formed by the non-held dice.
  task automatic model_step(input int k, input int n, input int f,
                            input int en, input int hold);
    int val, mult;
    m_done[k] = 0;
    case (m_mode[k])
      0: if (en != 0) begin m_mode[k] = 1; m_rv[k] = 0; end
      1: begin
        if (en != 0) begin
          val = 0; mult = 1;
          for (int i = 0; i < n; i++)
            if (((hold >> i) & 1) == 0) begin
              val += (m_face[k][i] - 1) * mult;
              mult *= f;
            end
          val = (val + 1) % mult;
          for (int i = 0; i < n; i++)
            if (((hold >> i) & 1) == 0) begin
              m_face[k][i] = val % f + 1;
              val /= f;
            end
        end else begin
          m_mode[k] = 2; m_cnt[k] = n; m_psum[k] = 0; m_peq[k] = 1;
          for (int i = 0; i < n; i++) begin
            m_psum[k] += m_face[k][i];
            if (m_face[k][i] != m_face[k][0]) m_peq[k] = 0;
          end
        end
      end
      default: begin
        m_cnt[k]--;
        if (m_cnt[k] == 0) begin
          m_sum[k] = m_psum[k]; m_eq[k] = m_peq[k];
          m_done[k] = 1; m_rv[k] = 1; m_mode[k] = 0;
        end
      end
    endcase
  endtask

  function automatic int model_faces(input int k, input int n);
    int v = 0;
    for (int i = 0; i < n; i++) v |= m_face[k][i] << (3 * i);
    return v;
  endfunction

  always @(posedge clk or posedge rst_a)
    if (rst_a) model_reset(0, 2);
    else       model_step(0, 2, 6, int'(en_a), int'(hold_a));

  always @(posedge clk or posedge rst_b)
    if (rst_b) model_reset(1, 3);
    else       model_step(1, 3, 4, int'(en_b), int'(hold_b));

  always @(negedge clk) begin
    chk("a_faces", int'(faces_a), model_faces(0, 2));
    chk("a_sum",   int'(sum_a),   m_sum[0]);
    chk("a_equal", int'(eq_a),    m_eq[0]);
    chk("a_busy",  int'(busy_a),  int'(m_mode[0] != 0));
    chk("a_done",  int'(done_a),  m_done[0]);
    chk("a_valid", int'(rv_a),    m_rv[0]);
    chk("b_faces", int'(faces_b), model_faces(1, 3));
    chk("b_sum",   int'(sum_b),   m_sum[1]);
    chk("b_equal", int'(eq_b),    m_eq[1]);
    chk("b_busy",  int'(busy_b),  int'(m_mode[1] != 0));
    chk("b_done",  int'(done_b),  m_done[1]);
    chk("b_valid", int'(rv_b),    m_rv[1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int die0_seq[7] = '{2, 3, 4, 5, 6, 1, 2};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    en_a = 1'b0; en_b = 1'b0; hold_a = '0; hold_b = '0;
    repeat (2) tick();
    chk("rst_faces", int'(faces_a), 6'o11);
    chk("rst_sum",   int'(sum_a), 2);
    chk("rst_equal", int'(eq_a), 1);
    chk("rst_flags", int'({busy_a, done_a, rv_a}), 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Odometer spin on 2x d6
    en_a = 1'b1;
    tick();
    chk("spin_entry_die0", int'(faces_a[2:0]), 1);
    for (int j = 0; j < 7; j++) begin
      tick();
      chk("spin_die0", int'(faces_a[2:0]), die0_seq[j]);
    end
    chk("spin_die1", int'(faces_a[5:3]), 2);
    en_a = 1'b0;
    repeat (2) tick();
    chk("latency_early_done", int'(done_a), 0);
    tick();
    chk("roll_done", int'(done_a), 1);
    chk("roll_sum", int'(sum_a), 4);
    chk("roll_equal", int'(eq_a), 1);
    chk("roll_busy", int'(busy_a), 0);
    chk("roll_valid", int'(rv_a), 1);

    // Hold masks
    en_a = 1'b1;
    repeat (2) tick();
    chk("hold_pre_die0", int'(faces_a[2:0]), 3);
    hold_a = 2'b01;
    repeat (3) tick();
    chk("hold_die0", int'(faces_a[2:0]), 3);
    chk("hold_die1", int'(faces_a[5:3]), 5);
    hold_a = 2'b11;
    for (int j = 0; j < 20; j++) begin
      tick();
      chk("hold_all_faces", int'(faces_a), 6'o53);
      chk("hold_all_busy", int'(busy_a), 1);
    end

    // Reset in the middle of SUM
    hold_a = '0; en_a = 1'b0;
    repeat (2) tick();
    #2 rst_a = 1'b1;
    #1;
    chk("midsum_faces", int'(faces_a), 6'o11);
    chk("midsum_sum", int'(sum_a), 2);
    chk("midsum_flags", int'({busy_a, done_a, rv_a}), 0);
    tick();
    rst_a = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("midsum_no_done", int'(done_a), 0);
    end

    // Retrigger with inputs toggling during SUM
    en_a = 1'b1;
    repeat (5) tick();
    en_a = 1'b0;
    tick();
    en_a = 1'b1; hold_a = 2'b11;
    tick();
    hold_a = 2'b01;
    tick();
    chk("retrig_done", int'(done_a), 1);
    chk("retrig_sum", int'(sum_a), 6);
    chk("retrig_equal", int'(eq_a), 0);
    chk("retrig_valid", int'(rv_a), 1);
    hold_a = '0;
    tick();
    chk("retrig_valid_clear", int'(rv_a), 0);
    chk("retrig_busy", int'(busy_a), 1);
    chk("retrig_faces_hold", int'(faces_a), 6'o15);
    tick();
    chk("retrig_resume", int'(faces_a), 6'o16);
    en_a = 1'b0;

    // Wrap and max sum on 3x d4
    en_b = 1'b1;
    repeat (64) tick();
    chk("wrap_max_faces", int'(faces_b), 9'o444);
    en_b = 1'b0;
    repeat (3) tick();
    chk("wrap_early_done", int'(done_b), 0);
    tick();
    chk("wrap_done", int'(done_b), 1);
    chk("wrap_sum", int'(sum_b), 12);
    chk("wrap_equal", int'(eq_b), 1);
    en_b = 1'b1;
    tick();
    chk("wrap_entry_faces", int'(faces_b), 9'o444);
    tick();
    chk("wrap_rollover", int'(faces_b), 9'o111);

    // Randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_a = 1'b0; rst_b = 1'b0;
      en_a = ($urandom_range(0, 7) != 0);
      en_b = ($urandom_range(0, 5) != 0);
      hold_a = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      hold_b = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0)};
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_a = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_b = 1'b1;
      end
    end
    tick();
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
